// File: rtl/bram_stream_pkg.sv
// Shared FSM encoding and skid-buffer sizing for the BRAM-to-stream burst controller.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;
  localparam logic [SKID_CNT_W:0] SKID_LIMIT = (SKID_CNT_W + 1)'(SKID_DEPTH);

  // Slots that will be taken once this cycle's pop retires: reads in flight plus remaining entries.
  function automatic logic [SKID_CNT_W:0] occupancy(input logic                  in_flight,
                                                    input logic [SKID_CNT_W-1:0] count,
                                                    input logic                  pop);
    return {{SKID_CNT_W{1'b0}}, in_flight} + {1'b0, count} - {{SKID_CNT_W{1'b0}}, pop};
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; the head register drives the stream outputs directly.
module skid_fifo2
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 1025
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic                  valid_o,
  output logic [SKID_CNT_W-1:0] count_o
);

  localparam logic [SKID_CNT_W-1:0] CNT_ZERO = {SKID_CNT_W{1'b0}};
  localparam logic [SKID_CNT_W-1:0] CNT_ONE  = {{(SKID_CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      ent0_q, ent0_d;
  logic [WIDTH-1:0]      ent1_q, ent1_d;
  logic [SKID_CNT_W-1:0] cnt_q, cnt_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == CNT_ZERO) begin
          ent0_d = din_i;
        end else begin
          ent1_d = din_i;
        end
        cnt_d = cnt_q + CNT_ONE;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - CNT_ONE;
      end
      2'b11: begin
        if (cnt_q == CNT_ONE) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= {WIDTH{1'b0}};
      ent1_q <= {WIDTH{1'b0}};
      cnt_q  <= CNT_ZERO;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = ent0_q;
  assign valid_o = (cnt_q != CNT_ZERO);
  assign count_o = cnt_q;

endmodule

// File: rtl/bram_stream_ctrl.sv
// Streams a burst of BRAM words out on a valid/ready interface through a 2-entry skid FIFO.
module bram_stream_ctrl
  import bram_stream_pkg::*;
#(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o
);

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              inflight_q;
  logic              inflight_last_q;

  logic                  pop_s;
  logic                  issue_s;
  logic                  last_issue_s;
  logic                  fifo_valid_s;
  logic [SKID_CNT_W-1:0] fifo_count_s;
  logic [DATA_W:0]       fifo_head_s;

  // The pop is counted as freeing its slot this cycle, which is what sustains one beat per cycle.
  assign pop_s        = fifo_valid_s & m_ready_i;
  assign issue_s      = (state_q == ST_RUN) && (issued_q < len_q) &&
                        (occupancy(inflight_q, fifo_count_s, pop_s) < SKID_LIMIT);
  assign last_issue_s = issue_s && ((issued_q + CNT_ONE) == len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    next_addr_d = next_addr_q;
    hold_addr_d = hold_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d       = length_i;
          issued_d    = {(ADDR_W+1){1'b0}};
          next_addr_d = base_addr_i;
          state_d     = (length_i == {(ADDR_W+1){1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          issued_d    = issued_q + CNT_ONE;
          next_addr_d = next_addr_q + ADDR_ONE;
          hold_addr_d = next_addr_q;
        end else begin
          issued_d = issued_q;
        end
        state_d = last_issue_s ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        if (pop_s && fifo_head_s[DATA_W]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        issued_d = {(ADDR_W+1){1'b0}};
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      len_q           <= {(ADDR_W+1){1'b0}};
      issued_q        <= {(ADDR_W+1){1'b0}};
      next_addr_q     <= {ADDR_W{1'b0}};
      hold_addr_q     <= {ADDR_W{1'b0}};
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      next_addr_q     <= next_addr_d;
      hold_addr_q     <= hold_addr_d;
      inflight_q      <= issue_s;
      inflight_last_q <= last_issue_s;
    end
  end

  // Read data lands one cycle after the enable, tagged with the last flag chosen at issue time.
  skid_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .din_i  ({inflight_last_q, bram_dout_i}),
    .pop_i  (pop_s),
    .dout_o (fifo_head_s),
    .valid_o(fifo_valid_s),
    .count_o(fifo_count_s)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign bram_en_o   = issue_s;
  assign bram_addr_o = issue_s ? next_addr_q : hold_addr_q;
  assign m_valid_o   = fifo_valid_s;
  assign m_data_o    = fifo_head_s[DATA_W-1:0];
  assign m_last_o    = fifo_head_s[DATA_W] & fifo_valid_s;

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Scoreboard bench for bram_stream_ctrl: expected reads and beats are queued at start, checked as they appear.
module tb_bram_stream_ctrl;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   length_i;
  logic              busy_o;
  logic              done_o;
  logic              bram_en_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_dout_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;
  logic              m_last_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [DATA_W:0]   q_beat[$];

  bram_stream_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .length_i   (length_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .bram_en_o  (bram_en_o),
    .bram_addr_o(bram_addr_o),
    .bram_dout_i(bram_dout_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_last_o   (m_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) begin
      w[k*32 +: 32] = {a, 26'(k)} ^ 32'h9E37_79B9;
    end
    return w;
  endfunction

  // BRAM model: one-cycle read latency, garbage on the bus when not enabled.
  always @(posedge clk) begin
    if (bram_en_o) bram_dout_i <= word_of(bram_addr_o);
    else           bram_dout_i <= {32{32'hDEAD_BEEF}};
  end

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 3) == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                           input int mode, input int dup_c, input string name);
    int c, beats, dones, first_valid_c, last_xfer_c, done_c;
    logic              stall_q;
    logic [DATA_W-1:0] pdata;
    logic              plast;
    logic [DATA_W:0]   exp_beat;
    logic [ADDR_W-1:0] ea;
    q_addr.delete();
    q_beat.delete();
    for (int i = 0; i < int'(len); i++) begin
      ea = base + ADDR_W'(i);
      q_addr.push_back(ea);
      q_beat.push_back({(i == int'(len) - 1), word_of(ea)});
    end
    c = 0; beats = 0; dones = 0; first_valid_c = -1; last_xfer_c = -1; done_c = -1;
    stall_q = 1'b0; pdata = '0; plast = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; length_i = len; m_ready_i = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      start_i = (c == dup_c);
      if (c == dup_c) begin
        base_addr_i = 6'd40;
        length_i    = 7'd3;
      end
      m_ready_i = ready_for(mode, c);
      @(negedge clk);
      if (bram_en_o) begin
        n_checks++;
        if (q_addr.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_read: bram_en at addr %0d, required no read", name, bram_addr_o);
        end else begin
          ea = q_addr.pop_front();
          if (bram_addr_o !== ea) begin
            n_fail++;
            $display("FAIL %s bram_addr: got %0d, required %0d", name, bram_addr_o, ea);
          end
        end
      end
      if (stall_q) begin
        n_checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== pdata || m_last_o !== plast) begin
          n_fail++;
          $display("FAIL %s stall_stable: valid=%b last=%b data[31:0]=%h, required valid=1 last=%b data[31:0]=%h",
                   name, m_valid_o, m_last_o, m_data_o[31:0], plast, pdata[31:0]);
        end
      end
      if (m_valid_o && first_valid_c < 0) first_valid_c = c;
      if (m_valid_o && m_ready_i) begin
        n_checks++;
        if (q_beat.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat: beat with data[31:0]=%h, required none", name, m_data_o[31:0]);
        end else begin
          exp_beat = q_beat.pop_front();
          if ({m_last_o, m_data_o} !== exp_beat) begin
            n_fail++;
            $display("FAIL %s beat%0d: last=%b data[31:0]=%h, required last=%b data[31:0]=%h",
                     name, beats, m_last_o, m_data_o[31:0], exp_beat[DATA_W], exp_beat[31:0]);
          end
        end
        beats++;
        if (m_last_o) last_xfer_c = c;
      end
      stall_q = m_valid_o && !m_ready_i;
      pdata   = m_data_o;
      plast   = m_last_o;
      if (done_o) begin
        dones++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      if (c >= 400) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: no completion after %0d cycles, required done", name, c);
        break;
      end
      c++;
    end
    n_checks++;
    if (beats != int'(len) || q_beat.size() != 0 || q_addr.size() != 0) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d beats (%0d reads left), required %0d beats", name, beats, q_addr.size(), len);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, dones);
    end
    n_checks++;
    if (done_c != ((len == 0) ? 0 : last_xfer_c + 1)) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d, required %0d", name, done_c, (len == 0) ? 0 : last_xfer_c + 1);
    end
    if (len != 0) begin
      n_checks++;
      if (first_valid_c != 2) begin
        n_fail++;
        $display("FAIL %s first_valid_latency: got %0d, required 2", name, first_valid_c);
      end
    end
    if (mode == 0 && len != 0) begin
      n_checks++;
      if (last_xfer_c != int'(len) + 1) begin
        n_fail++;
        $display("FAIL %s throughput: last beat at cycle %0d, required %0d", name, last_xfer_c, int'(len) + 1);
      end
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_done: busy=%b, required 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; length_i = '0; m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      n_checks++;
      if ({busy_o, done_o, bram_en_o, m_valid_o, m_last_o} !== 5'b0 || bram_addr_o !== '0 || m_data_o !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%0d valid=%b last=%b data[31:0]=%h, required all 0",
                 busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_o, m_data_o[31:0]);
      end
    end
  endtask

  task automatic test_full_burst();
    run_burst(6'd0, 7'd64, 0, -1, "full_burst");
  endtask

  task automatic test_wrap();
    run_burst(6'd60, 7'd8, 0, -1, "wrap");
  endtask

  task automatic test_backpressure();
    run_burst(6'd5, 7'd10, 1, -1, "backpressure");
  endtask

  task automatic test_zero_length();
    run_burst(6'd7, 7'd0, 0, -1, "zero_length");
  endtask

  task automatic test_start_while_busy();
    run_burst(6'd10, 7'd16, 0, 5, "start_busy");
  endtask

  task automatic test_abort();
    int beats, dones;
    beats = 0; dones = 0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = 6'd0; length_i = 7'd20; m_ready_i = 1'b1;
    for (int c = 0; c < 100 && beats < 5; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      if (m_valid_o && m_ready_i) beats++;
      if (done_o) dones++;
    end
    n_checks++;
    if (beats != 5 || dones != 0) begin
      n_fail++;
      $display("FAIL abort_pre: got %0d beats %0d dones, required 5 beats 0 dones", beats, dones);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, bram_en_o, m_valid_o, m_last_o} !== 5'b0 || bram_addr_o !== '0 || m_data_o !== '0) begin
      n_fail++;
      $display("FAIL abort_immediate: busy=%b done=%b en=%b addr=%0d valid=%b last=%b, required all 0",
               busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold: done=%b busy=%b valid=%b, required 0", done_o, busy_o, m_valid_o);
      end
    end
    run_burst(6'd0, 7'd4, 0, -1, "abort_restart");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W:0] lens[4] = '{7'd1, 7'd64, 7'd2, 7'd33};
    for (int i = 0; i < 4; i++) begin
      run_burst(ADDR_W'($urandom_range(0, 63)), lens[i], 2, -1, "random_ready");
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_stream_ctrl.md
BRAM_STREAM_CTRL -- requirements
Module: bram_stream_ctrl

Interface
REQ-001 Parameter DATA_W, default 1024, SHALL set the BRAM word and output data width in bits.
REQ-002 Parameter ADDR_W, default 6, SHALL set the BRAM address width; DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  SHALL be the clock for all sequential logic, rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  SHALL give the first BRAM address of the burst, captured with start.
REQ-007 length  input  ADDR_W+1  SHALL give the beat count, 0..DEPTH, captured with start.
REQ-008 busy  output  1  SHALL be high in every state other than IDLE.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking burst completion.
REQ-010 bram_en  output  1  SHALL be the BRAM read enable.
REQ-011 bram_addr  output  ADDR_W  SHALL be the BRAM read address.
REQ-012 bram_dout  input  DATA_W  SHALL be the BRAM read data, valid exactly 1 cycle after bram_en.
REQ-013 m_data  output  DATA_W  SHALL be the output beat data to the datapath.
REQ-014 m_valid  output  1  SHALL mark m_data valid.
REQ-015 m_ready  input  1  SHALL be the downstream acceptance signal; a beat transfers when m_valid and m_ready are both high.
REQ-016 m_last  output  1  SHALL mark the final beat of a burst, qualified by m_valid.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE: on start with length>0 it SHALL go to RUN; on start with length=0 it SHALL go to DONE; otherwise it SHALL stay in IDLE.
REQ-019 RUN: the block SHALL issue one read (bram_en=1) in every cycle in which (reads in flight + skid entries occupied) < 2 and issued < length.
REQ-020 The read address SHALL start at base_addr and increment by 1 per issued read, wrapping modulo DEPTH (63 -> 0 at the default width).
REQ-021 RUN SHALL go to DRAIN in the cycle after the length-th read is issued.
REQ-022 DRAIN SHALL go to DONE on the cycle in which the m_last beat transfers.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-024 Returning read data SHALL be captured into a 2-entry skid FIFO; m_data/m_valid SHALL be driven from the FIFO head, with no combinational path from bram_dout to m_data.
REQ-025 With m_ready held high, throughput SHALL be 1 beat/cycle, and the first m_valid SHALL rise 2 cycles after start is sampled.
REQ-026 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable; the FIFO SHALL never overflow or drop a beat.
REQ-027 m_last SHALL be high on exactly the length-th beat only.
REQ-028 A start pulse while busy=1 SHALL be ignored with no effect on the burst in progress.
REQ-029 A simultaneous FIFO push and pop SHALL keep the occupancy unchanged and preserve beat order.
REQ-030 bram_addr SHALL hold its last value when bram_en=0.

Reset
REQ-031 Asserting rst SHALL immediately force state=IDLE, the FIFO empty, and the counters to 0.
REQ-032 During and after reset: busy=0, done=0, bram_en=0, bram_addr=0, m_valid=0, m_last=0, m_data=0.
REQ-033 rst asserted mid-burst SHALL abort the burst without a done pulse; the first start after deassertion SHALL run a fresh burst normally.

Structure
REQ-034 The FSM state encodings and the skid depth constant (2) SHALL reside in the shared package bram_stream_pkg.
REQ-035 The skid FIFO SHALL be the sub-module skid_fifo2 (2 entries, DATA_W+1 bits wide, carrying data plus last).

Verification
REQ-036 Full burst: base=0, length=64, m_ready=1 -> 64 consecutive beats at addresses 0..63, m_last on beat 64, done 1 cycle later.
REQ-037 Wrap-around: base=60, length=8 -> read addresses 60,61,62,63,0,1,2,3 in order.
REQ-038 Backpressure: length=10 with m_ready toggling 1,0,0,1,... -> 10 beats, in order, with no loss or duplication, and data stable while stalled.
REQ-039 Zero length: start with length=0 -> no bram_en, no m_valid, and done 1 cycle after start.
REQ-040 Abort: rst asserted on beat 5 of 20 -> all outputs 0 immediately; a following start with base=0, length=4 -> 4 beats and done.
REQ-041 Start while busy: a second start during a length=16 burst -> ignored; exactly 16 beats and a single done pulse.
